// File: rtl/os_array_ctrl_if.sv
// Handshake/bus bundle between the output-stationary array controller and
// its requester / drain consumer.
//   start, k_len     : tile request and its reduction length
//   busy, done       : controller status
//   feed_row_en/col  : skewed operand-buffer read enables
//   acc_enable       : PE accumulate enable
//   load_en          : PE accumulator -> shadow transfer pulse
//   drain_row_sel    : shadow row presented on the output mux
//   out_valid/ready  : drain handshake, out_last marks row ROWS-1
interface os_array_ctrl_if #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_WIDTH = 16
);
    logic                    start;
    logic [K_WIDTH-1:0]      k_len;
    logic                    busy;
    logic                    done;
    logic [ROWS-1:0]         feed_row_en;
    logic [COLS-1:0]         feed_col_en;
    logic                    acc_enable;
    logic                    load_en;
    logic [$clog2(ROWS)-1:0] drain_row_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    // master: requester + drain consumer
    modport master (
        output start, k_len, out_ready,
        input  busy, done, feed_row_en, feed_col_en, acc_enable, load_en,
               drain_row_sel, out_valid, out_last
    );

    // slave: the controller itself
    modport slave (
        input  start, k_len, out_ready,
        output busy, done, feed_row_en, feed_col_en, acc_enable, load_en,
               drain_row_sel, out_valid, out_last
    );
endinterface

// File: rtl/os_array_ctrl.sv
// Sequencer for an output-stationary ROWS x COLS PE array. One tile:
// FEED (skewed operand streaming, accumulate), optional SETTLE for array
// pipeline depth, LOAD (accumulators -> shadow regs), DRAIN (one shadow row
// per accepted handshake), DONE (one-cycle completion pulse).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : os_array_ctrl_if.slave (request, status, enables, drain)
module os_array_ctrl #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int K_WIDTH  = 16,
    parameter int PIPE_LAT = 0
) (
    input logic             clk,
    input logic             rst_n,
    os_array_ctrl_if.slave  bus
);
    // Wide enough for K + ROWS + COLS - 3 at K = 2^K_WIDTH-1 without wrap.
    localparam int TW = K_WIDTH + $clog2(ROWS + COLS) + 1;
    localparam int RW = $clog2(ROWS);

    typedef enum logic [2:0] {IDLE, FEED, SETTLE, LOAD, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      t_q, t_d;
    logic [K_WIDTH-1:0] k_q, k_d;
    logic [RW-1:0]      row_q, row_d;

    logic               busy_q, done_q, acc_q, load_q, valid_q, last_q;
    logic [ROWS-1:0]    row_en_q, row_en_d;
    logic [COLS-1:0]    col_en_q, col_en_d;

    logic               feed_last;
    assign feed_last = (t_q == TW'(k_q) + TW'(ROWS + COLS - 3));

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && (bus.k_len != '0)) begin
                    state_d = FEED;
                    t_d     = '0;
                    k_d     = bus.k_len;
                end
            end
            FEED: begin
                if (feed_last) begin
                    t_d     = '0;
                    state_d = (PIPE_LAT > 0) ? SETTLE : LOAD;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            SETTLE: begin
                // t is reused as the settle counter.
                if (t_q == TW'(PIPE_LAT - 1)) begin
                    t_d     = '0;
                    state_d = LOAD;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            LOAD: begin
                state_d = DRAIN;
                row_d   = '0;
            end
            DRAIN: begin
                // out_valid is high for the whole of DRAIN, so out_ready alone
                // completes the handshake.
                if (bus.out_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        state_d = DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Skew: lane i reads during t in [i, i+K-1]. Outputs are built from the
    // next-state values so the registered copies line up with the state.
    for (genvar i = 0; i < ROWS; i++) begin : g_row_en
        assign row_en_d[i] = (state_d == FEED) && (t_d >= TW'(i)) &&
                             (t_d < TW'(i) + TW'(k_d));
    end
    for (genvar j = 0; j < COLS; j++) begin : g_col_en
        assign col_en_d[j] = (state_d == FEED) && (t_d >= TW'(j)) &&
                             (t_d < TW'(j) + TW'(k_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            t_q      <= '0;
            k_q      <= '0;
            row_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= 1'b0;
            load_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            row_en_q <= '0;
            col_en_q <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            k_q      <= k_d;
            row_q    <= row_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
            acc_q    <= (state_d == FEED);
            load_q   <= (state_d == LOAD);
            valid_q  <= (state_d == DRAIN);
            last_q   <= (state_d == DRAIN) && (row_d == RW'(ROWS - 1));
            row_en_q <= row_en_d;
            col_en_q <= col_en_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.acc_enable    = acc_q;
    assign bus.load_en       = load_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_last      = last_q;
    assign bus.drain_row_sel = row_q;
    assign bus.feed_row_en   = row_en_q;
    assign bus.feed_col_en   = col_en_q;
endmodule

// File: tb/tb_os_array_ctrl.sv
module tb_os_array_ctrl;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KW   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    os_array_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW)) b0 ();
    os_array_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW)) b1 ();

    os_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW), .PIPE_LAT(0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    os_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW), .PIPE_LAT(2))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    logic          sel       = 1'b0;
    logic          start_drv = 1'b0;
    logic          rdy_drv   = 1'b0;
    logic [KW-1:0] k_drv     = '0;

    assign b0.start     = start_drv & ~sel;
    assign b1.start     = start_drv & sel;
    assign b0.k_len     = k_drv;
    assign b1.k_len     = k_drv;
    assign b0.out_ready = rdy_drv;
    assign b1.out_ready = rdy_drv;

    logic            m_busy, m_done, m_acc, m_load, m_valid, m_last;
    logic [ROWS-1:0] m_ren;
    logic [COLS-1:0] m_cen;
    logic [1:0]      m_sel;
    logic [15:0]     outs0, outs1;

    always_comb begin
        m_busy  = sel ? b1.busy          : b0.busy;
        m_done  = sel ? b1.done          : b0.done;
        m_acc   = sel ? b1.acc_enable    : b0.acc_enable;
        m_load  = sel ? b1.load_en       : b0.load_en;
        m_valid = sel ? b1.out_valid     : b0.out_valid;
        m_last  = sel ? b1.out_last      : b0.out_last;
        m_ren   = sel ? b1.feed_row_en   : b0.feed_row_en;
        m_cen   = sel ? b1.feed_col_en   : b0.feed_col_en;
        m_sel   = sel ? b1.drain_row_sel : b0.drain_row_sel;
    end

    assign outs0 = {b0.busy, b0.done, b0.feed_row_en, b0.feed_col_en, b0.acc_enable,
                    b0.load_en, b0.drain_row_sel, b0.out_valid, b0.out_last};
    assign outs1 = {b1.busy, b1.done, b1.feed_row_en, b1.feed_col_en, b1.acc_enable,
                    b1.load_en, b1.drain_row_sel, b1.out_valid, b1.out_last};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // rdy: 0 = always ready, 1 = toggle each cycle, 2 = random
    typedef struct {
        bit sel;
        int k;
        int rdy;
        bit noise;
        int exp_feed;
        int exp_settle;
    } vec_t;

    vec_t vecs[7];
    int   sbq[$];

    task automatic run_tile(input vec_t v, input string tag);
        int feed = 0, settle = 0, loads = 0, dones = 0, beats = 0;
        int en_err = 0, stall_err = 0, order_err = 0, last_err = 0, done_err = 0;
        int cyc = 0, budget, t, exp_r;
        bit prev_last_hs = 0, stall = 0, exp_en;
        logic [1:0] stall_row = '0;
        sel = v.sel;
        sbq.delete();
        for (int r = 0; r < ROWS; r++) sbq.push_back(r);
        @(negedge clk);
        start_drv = 1'b1;
        k_drv     = v.k[KW-1:0];
        @(negedge clk);
        start_drv = 1'b0;
        budget = v.k + 200;
        while (dones == 0 && cyc < budget) begin
            cyc++;
            start_drv = 1'b0;
            if (m_acc) begin
                t = feed;
                for (int i = 0; i < ROWS; i++) begin
                    exp_en = (t >= i) && (t <= i + v.k - 1);
                    if (m_ren[i] !== exp_en) en_err++;
                end
                for (int j = 0; j < COLS; j++) begin
                    exp_en = (t >= j) && (t <= j + v.k - 1);
                    if (m_cen[j] !== exp_en) en_err++;
                end
                feed++;
                if (v.noise && feed == 3) begin
                    start_drv = 1'b1;
                    k_drv     = 16'd7;
                end
            end else if (m_busy && feed > 0 && loads == 0 && !m_load) begin
                settle++;
            end
            if (m_load) loads++;
            if (m_done) begin
                dones++;
                if (!prev_last_hs || m_valid) done_err++;
            end
            prev_last_hs = 1'b0;
            if (stall) begin
                if (m_sel !== stall_row) stall_err++;
                stall = 1'b0;
            end
            if (m_valid) begin
                if (v.noise && beats == 0) begin
                    start_drv = 1'b1;
                    k_drv     = 16'd7;
                end
                case (v.rdy)
                    0:       rdy_drv = 1'b1;
                    1:       rdy_drv = ~rdy_drv;
                    default: rdy_drv = 1'($urandom_range(0, 1));
                endcase
                if (rdy_drv) begin
                    beats++;
                    if (sbq.size() == 0) begin
                        order_err++;
                    end else begin
                        exp_r = sbq.pop_front();
                        if (m_sel !== 2'(exp_r)) order_err++;
                        if (m_last !== (exp_r == ROWS - 1)) last_err++;
                        if (exp_r == ROWS - 1) prev_last_hs = 1'b1;
                    end
                end else begin
                    stall     = 1'b1;
                    stall_row = m_sel;
                end
            end else begin
                rdy_drv = 1'b0;
            end
            if (dones == 0) @(negedge clk);
        end
        @(negedge clk);
        check({tag, "_feed_cycles"}, feed, v.exp_feed);
        check({tag, "_settle_cycles"}, settle, v.exp_settle);
        check({tag, "_load_pulses"}, loads, 1);
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_done_timing"}, done_err, 0);
        check({tag, "_feed_enables"}, en_err, 0);
        check({tag, "_beat_order"}, order_err, 0);
        check({tag, "_out_last"}, last_err, 0);
        check({tag, "_stall_stable"}, stall_err, 0);
        check({tag, "_beats"}, beats, ROWS);
        check({tag, "_sb_empty"}, sbq.size(), 0);
        check({tag, "_idle_after"}, {m_busy, m_done, m_valid}, 0);
        rdy_drv = 1'b0;
    endtask

    task automatic reset_abort(input bit in_drain, input string tag);
        int n = 0, feed = 0, stray = 0;
        sel = 1'b0;
        @(negedge clk);
        start_drv = 1'b1;
        k_drv     = 16'd3;
        @(negedge clk);
        start_drv = 1'b0;
        rdy_drv   = 1'b0;
        while (n < 100) begin
            if (!in_drain && m_acc && feed == 4) break;
            if (in_drain && m_valid) break;
            if (m_acc) feed++;
            n++;
            @(negedge clk);
        end
        check({tag, "_reached"}, n < 100, 1);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_async_outs0"}, outs0, 0);
        check({tag, "_async_outs1"}, outs1, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m_busy || m_load || m_done || m_valid) stray++;
        end
        check({tag, "_no_stale_activity"}, stray, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_hi;
        vecs[0] = '{0, 3,     0, 0, 9,     0};
        vecs[1] = '{0, 3,     1, 0, 9,     0};
        vecs[2] = '{0, 3,     2, 1, 9,     0};
        vecs[3] = '{1, 1,     0, 0, 7,     2};
        vecs[4] = '{0, 1,     1, 1, 7,     0};
        vecs[5] = '{1, 5,     2, 0, 11,    2};
        vecs[6] = '{0, 65535, 0, 0, 65541, 0};

        #2 rst_n = 1'b0;
        #1;
        check("reset_outs0", outs0, 0);
        check("reset_outs1", outs1, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // k_len == 0 must be ignored
        @(negedge clk);
        start_drv = 1'b1;
        k_drv     = '0;
        @(negedge clk);
        start_drv = 1'b0;
        busy_hi = 0;
        for (int c = 0; c < 5; c++) begin
            if (b0.busy || b1.busy || b0.acc_enable || b0.feed_row_en != 0) busy_hi++;
            @(negedge clk);
        end
        check("kzero_ignored", busy_hi, 0);

        for (int i = 0; i < 7; i++) run_tile(vecs[i], $sformatf("vec%0d", i));

        reset_abort(1'b0, "rst_feed");
        run_tile(vecs[0], "after_rst_feed");
        reset_abort(1'b1, "rst_drain");
        run_tile(vecs[0], "after_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/os_array_ctrl.md
OS_ARRAY_CTRL -- requirements
Module: os_array_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, PE array row count (>=2).
REQ-002 SHALL have parameter COLS, default 4, PE array column count (>=2).
REQ-003 SHALL have parameter K_WIDTH, default 16, width of reduction-length field.
REQ-004 SHALL have parameter PIPE_LAT, default 0, extra array settling cycles before capture.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle request to run one matrix tile.
REQ-008 k_len  input  K_WIDTH  reduction length; sampled with accepted start.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse when a tile fully completes.
REQ-011 feed_row_en  output  ROWS  per-row skewed read enable for row operand buffers.
REQ-012 feed_col_en  output  COLS  per-column skewed read enable for column operand buffers.
REQ-013 acc_enable  output  1  drives PE acc_enable during FEED.
REQ-014 load_en  output  1  one-cycle pulse driving PE load_en: moves accumulators to shadow registers and clears them.
REQ-015 drain_row_sel  output  $clog2(ROWS)  row of shadow results presented to the output mux.
REQ-016 out_valid  output  1  shadow row on the output mux is valid.
REQ-017 out_ready  input  1  downstream accepts current row.
REQ-018 out_last  output  1  high with out_valid on row ROWS-1.

Function
REQ-019 SHALL implement states IDLE, FEED, SETTLE, LOAD, DRAIN, DONE.
REQ-020 IDLE: start=1 with k_len!=0 SHALL latch k_len, clear cycle counter t to 0, enter FEED next cycle.
REQ-021 start with k_len==0, or start outside IDLE, SHALL be ignored (no state, output, or latched-value change).
REQ-022 FEED SHALL last exactly K+ROWS+COLS-2 cycles, K = latched k_len; t counts 0..K+ROWS+COLS-3.
REQ-023 feed_row_en[i] SHALL be high exactly when i <= t <= i+K-1 in FEED; feed_col_en[j] likewise with j.
REQ-024 acc_enable SHALL be high for every FEED cycle and low otherwise.
REQ-025 After FEED, SETTLE SHALL last PIPE_LAT cycles (skipped when PIPE_LAT=0).
REQ-026 LOAD SHALL last exactly one cycle with load_en=1; load_en SHALL be 0 in all other states.
REQ-027 DRAIN SHALL start with drain_row_sel=0, out_valid=1; on out_valid&out_ready drain_row_sel SHALL increment.
REQ-028 While out_valid=1 and out_ready=0, drain_row_sel SHALL hold stable.
REQ-029 Handshake on row ROWS-1 SHALL move to DONE; out_valid low in DONE.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE; start in DONE is ignored.
REQ-031 Counter t SHALL be K_WIDTH+$clog2(ROWS+COLS)+1 bits; k_len = 2^K_WIDTH-1 SHALL not wrap.
REQ-032 All outputs SHALL be registered (Moore, from state and counters), no combinational path from inputs.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, t=0, latched K=0, and all outputs 0 (busy, done, feed enables, acc_enable, load_en, drain_row_sel, out_valid, out_last).
REQ-034 Reset asserted mid-FEED or mid-DRAIN SHALL abort the tile with no load_en or done pulse; first start after release SHALL behave as from power-up.

Verification
REQ-035 ROWS=COLS=4, PIPE_LAT=0, start k_len=3 -> FEED 9 cycles; feed_row_en[0] t=0..2, feed_row_en[3] t=3..5; load_en one cycle after FEED; out_ready=1 gives 4 beats, out_last on beat 4, done next cycle.
REQ-036 Same, out_ready toggled 0/1 each cycle -> drain_row_sel stable while stalled; exactly 4 accepted beats in order 0,1,2,3.
REQ-037 start with k_len=0, and start pulsed during FEED/DRAIN -> no effect: busy, latched K, and counters unchanged.
REQ-038 PIPE_LAT=2, k_len=1 -> FEED 7 cycles, 2 SETTLE cycles, then load_en; acc_enable low in SETTLE.
REQ-039 rst_n dropped at FEED t=4 -> all outputs 0 asynchronously; after release start k_len=3 reproduces REQ-035 timing.
REQ-040 k_len=65535 (K_WIDTH=16) -> FEED exactly 65541 cycles, single load_en, no counter wrap.
